flag_event_rx: RTL
==================

# flag_event_rx

Receive-side endpoint for CHANNELS independent toggle-handshake flag channels arriving from foreign clock domains. Each channel's toggle is synchronised into clk, converted into a pending event, and arbitrated round-robin onto a single valid/ready event port. The per-channel acknowledge toggle is returned only when the consumer accepts the event, so every source stays busy until its event is actually consumed. Sits at the clk-domain boundary of the power/event logic as the multi-channel, back-pressured generation of the single-flag crosser.

## Interface
- CHANNELS, 4: number of flag channels, 1..32.
- SYNC_STAGES, 2: synchroniser depth per channel, 2 or more (elaboration error below 2).
- ID_W, derived: max(1, $clog2(CHANNELS)); not overridable.

- clk  in  1  sole clock of the block.
- rst  in  1  synchronous, active-high reset.
- toggle_in  in  CHANNELS  asynchronous flag toggles, one per channel, each from the source's own domain.
- ack_toggle  out  CHANNELS  registered acknowledge toggles returned to the sources.
- ch_en  in  CHANNELS  per-channel arbitration enable, sampled each clk.
- evt_valid  out  1  an event is presented.
- evt_id  out  ID_W  channel index of the presented event.
- evt_ready  in  1  consumer accepts the event when it is high together with evt_valid.
- pending  out  CHANNELS  per-channel unacknowledged-event status.

## Operation
- Per channel i: sync[i] is a SYNC_STAGES shift register clocked on clk; s_i is its last stage.
- pending[i] = s_i XOR ack_q[i], combinational from registers.
- ack_toggle = ack_q, driven directly from flops with no logic after them.
- Eligible set: pending AND ch_en. If evt_valid is high, the channel at evt_id is also removed from the set.
- Round-robin pointer rr holds the search start index. On a grant, the winner is the first eligible channel at or after rr, wrapping modulo CHANNELS.
- Output register load:
  - evt_valid=0 and the eligible set is non-empty: on the next edge set evt_valid=1, evt_id=winner, rr=winner+1 (wraps to 0).
  - Handshake (evt_valid & evt_ready): on the same edge, ack_q[evt_id] toggles. If another channel is eligible, evt_valid stays 1 and evt_id loads the next winner (back-to-back). Otherwise evt_valid goes to 0.
  - evt_valid=1 and evt_ready=0: evt_id, evt_valid and rr hold.
- A presented event is never withdrawn. Deasserting ch_en[evt_id] while evt_valid is high does not drop it.
- Masked channels (ch_en=0) keep pending=1. Their source remains busy. They are arbitrated once re-enabled.
- A source must not toggle again while its own pending/busy is set. If it does, the extra toggle cancels the pending event. This is a protocol violation and is not detected.
- Simultaneous new arrivals on several channels are served one per accepted handshake, in round-robin order from rr.

## Timing
- Reset values: sync all 0, ack_q 0, ack_toggle 0, evt_valid 0, evt_id 0, rr 0, pending 0.
- Latency: toggle_in[i] changes before edge 0, with ch_en[i]=1 and the block idle.
  - s_i changes at edge SYNC_STAGES; pending[i]=1 in the cycle after it.
  - evt_valid=1 with evt_id=i after edge SYNC_STAGES+1.
- pending[i] falls in the cycle after the accepting edge, because ack_q toggles at that edge.
- The source sees ack_toggle change one clk after acceptance, then applies its own synchroniser.
- Throughput: one event per clk while eligible events exist and evt_ready=1.
- Reset mid-operation:
  - Any presented or pending event is dropped and ack_q returns to 0.
  - A channel whose source toggle is still 1 after reset is re-reported as a new event after SYNC_STAGES+1 cycles.
  - Sources must be reset together with this block.

## Structure
- Shared package cdc_pkg holds MIN_SYNC_STAGES = 2 and the ID-width function used to derive ID_W.
- Sub-module toggle_sync has parameter STAGES and ports clk, rst, d, q. It is instantiated CHANNELS times and carries synthesis attributes for async_reg and no retiming.
- Arbiter and output register stay in flag_event_rx.

## Test plan
- Single event, CHANNELS=4, SYNC_STAGES=2, evt_ready=1: toggle_in[2] goes 0→1 → evt_valid=1, evt_id=2 after edge 3; ack_toggle[2]=1 one cycle later; pending[2]=0.
- Simultaneous arrivals: toggle_in goes 0000→1111 with rr=0 and evt_ready=1 → evt_id sequence 0,1,2,3 on consecutive cycles; ack_toggle=1111; evt_valid=0 afterwards.
- Back-pressure: evt_ready=0 for 10 cycles with channel 1 pending → evt_id=1 stays stable and evt_valid stays 1; ack_toggle[1] is unchanged until evt_ready rises.
- Mask: ch_en=1011 and channels 2 and 3 toggle → only channel 3 is reported; pending[2] stays 1. Setting ch_en[2]=1 → channel 2 is reported next.
- Fairness: channels 0 and 3 toggle again right after each grant → grants alternate 0,3,0,3 with no starvation.
- Reset mid-operation: rst for 1 cycle while evt_valid=1, evt_id=1 and toggle_in[1]=1 → all outputs return to reset values; the event for channel 1 reappears SYNC_STAGES+1 cycles after rst falls.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the clock-domain-crossing flag endpoints.
package cdc_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  // Width of a channel index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser bringing one asynchronous toggle level into clk.
module toggle_sync
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("toggle_sync: STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  (* async_reg = "true", retiming_forward = 0, retiming_backward = 0 *)
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/flag_event_rx.sv
// Multi-channel toggle-handshake receiver: synchronised toggles become pending
// events, served round-robin on a valid/ready port and acknowledged on accept.
module flag_event_rx
  import cdc_pkg::*;
#(
  parameter  int CHANNELS    = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = id_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] toggle_in,
  output logic [CHANNELS-1:0] ack_toggle,
  input  logic [CHANNELS-1:0] ch_en,
  output logic                evt_valid,
  output logic [ID_W-1:0]     evt_id,
  input  logic                evt_ready,
  output logic [CHANNELS-1:0] pending
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("flag_event_rx: CHANNELS must be in 1..32");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("flag_event_rx: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  logic [CHANNELS-1:0] sync_s;
  logic [CHANNELS-1:0] ack_q, ack_d;
  logic                valid_q, valid_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [CHANNELS-1:0] eligible;
  logic                found;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     winner_next;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_sync
    toggle_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (toggle_in[c]),
      .q   (sync_s[c])
    );
  end

  assign pending    = sync_s ^ ack_q;
  assign ack_toggle = ack_q;
  assign evt_valid  = valid_q;
  assign evt_id     = id_q;

  // The event already on the port is excluded so a back-to-back load picks a different channel.
  always_comb begin
    int idx;
    eligible    = pending & ch_en;
    found       = 1'b0;
    winner      = '0;
    winner_next = '0;
    idx         = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (valid_q && id_q == ID_W'(c)) begin
        eligible[c] = 1'b0;
      end
    end
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(rr_q) + k) % CHANNELS;
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        winner      = ID_W'(idx);
        winner_next = (idx == CHANNELS - 1) ? '0 : ID_W'(idx + 1);
      end
    end
  end

  always_comb begin
    ack_d   = ack_q;
    valid_d = valid_q;
    id_d    = id_q;
    rr_d    = rr_q;
    if (!valid_q) begin
      if (found) begin
        valid_d = 1'b1;
        id_d    = winner;
        rr_d    = winner_next;
      end
    end else if (evt_ready) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (id_q == ID_W'(c)) begin
          ack_d[c] = ~ack_q[c];
        end
      end
      if (found) begin
        id_d = winner;
        rr_d = winner_next;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      rr_q    <= '0;
    end else begin
      ack_q   <= ack_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

endmodule
